// File: rtl/mem_arbiter.sv
// Multi-channel read arbiter: per-channel FIFOs feed one single-outstanding
// memory read port; completed reads are broadcast tagged with their channel.

module mem_arbiter_fifo #(
    parameter int QLOG = 3,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] head,
    output logic          empty,
    output logic          full,
    output logic          ovf
);
    localparam int DEPTH = 1 << QLOG;

    logic [AW-1:0]   mem [DEPTH];
    logic [QLOG-1:0] rd_ptr, wr_ptr;
    logic [QLOG:0]   count;
    logic            do_push;

    assign empty = (count == '0);
    assign full  = (count == (QLOG+1)'(DEPTH));
    assign head  = mem[rd_ptr];
    // a pop in the same cycle frees the slot, so a full queue still accepts
    assign do_push = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)      count <= count + 1'b1;
            else if (pop && !do_push) count <= count - 1'b1;
            if (push && !do_push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module mem_arbiter #(
    parameter int NCH  = 2,
    parameter int QLOG = 3,
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int RR   = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NCH-1:0]                         req_valid,
    input  logic [NCH*AW-1:0]                      req_addr,
    output logic [NCH-1:0]                         q_full,
    output logic [NCH-1:0]                         q_ovf,
    output logic                                   mem_re,
    output logic [AW-1:0]                          mem_raddr,
    input  logic                                   mem_ready,
    input  logic [DW-1:0]                          mem_rdata,
    output logic                                   resp_valid,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] resp_ch,
    output logic [AW-1:0]                          resp_addr,
    output logic [DW-1:0]                          resp_data
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [NCH-1:0][AW-1:0] heads;
    logic [NCH-1:0]         empty, pop;
    logic [1:0]             state;
    logic [CW-1:0]          cur_ch, rr_ptr, win, idx;
    logic                   any, grant;

    for (genvar c = 0; c < NCH; c++) begin : g_q
        mem_arbiter_fifo #(.QLOG(QLOG), .AW(AW)) u_q (
            .clk   (clk),
            .reset (reset),
            .push  (req_valid[c]),
            .pop   (pop[c]),
            .din   (req_addr[c*AW +: AW]),
            .head  (heads[c]),
            .empty (empty[c]),
            .full  (q_full[c]),
            .ovf   (q_ovf[c])
        );
    end

    assign any = |(~empty);

    // later loop iterations overwrite earlier ones: highest index wins for
    // fixed priority, nearest-after-rr_ptr wins for round-robin
    always_comb begin
        win = '0;
        idx = '0;
        if (RR == 0) begin
            for (int c = 0; c < NCH; c++)
                if (!empty[c]) win = CW'(c);
        end else begin
            for (int k = NCH; k >= 1; k--) begin
                idx = CW'((int'(rr_ptr) + k) % NCH);
                if (!empty[idx]) win = idx;
            end
        end
    end

    assign grant = any && ((state == S_IDLE) || (state == S_WAIT && mem_ready));
    assign pop   = grant ? (NCH'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_re     <= 1'b0;
            mem_raddr  <= '0;
            cur_ch     <= '0;
            rr_ptr     <= CW'(NCH - 1);
            resp_valid <= 1'b0;
            resp_ch    <= '0;
            resp_addr  <= '0;
            resp_data  <= '0;
        end else begin
            mem_re     <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                S_IDLE:  if (grant) state <= S_ISSUE;
                S_ISSUE: begin
                    mem_re <= 1'b1;
                    state  <= S_WAIT;
                end
                S_WAIT: if (mem_ready) begin
                    resp_valid <= 1'b1;
                    resp_ch    <= cur_ch;
                    resp_addr  <= mem_raddr;
                    resp_data  <= mem_rdata;
                    state      <= grant ? S_ISSUE : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (grant) begin
                mem_raddr <= heads[win];
                cur_ch    <= win;
                rr_ptr    <= win;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-priority instance (NCH=2, QLOG=2) with directed
// vectors and corner sequences, round-robin instance (NCH=4) with random traffic.

module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: NCH=2, QLOG=2, RR=0
    logic        a_reset;
    logic [1:0]  a_req_valid, a_q_full, a_q_ovf;
    logic [31:0] a_req_addr;
    logic        a_mem_re, a_mem_ready, a_resp_valid;
    logic [15:0] a_mem_raddr, a_mem_rdata, a_resp_addr, a_resp_data;
    logic [0:0]  a_resp_ch;

    // instance B: NCH=4, QLOG=3, RR=1
    logic        b_reset;
    logic [3:0]  b_req_valid, b_q_full, b_q_ovf;
    logic [63:0] b_req_addr;
    logic        b_mem_re, b_mem_ready, b_resp_valid;
    logic [15:0] b_mem_raddr, b_mem_rdata, b_resp_addr, b_resp_data;
    logic [1:0]  b_resp_ch;

    mem_arbiter #(.NCH(2), .QLOG(2), .AW(16), .DW(16), .RR(0)) u_a (
        .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_addr(a_req_addr),
        .q_full(a_q_full), .q_ovf(a_q_ovf), .mem_re(a_mem_re), .mem_raddr(a_mem_raddr),
        .mem_ready(a_mem_ready), .mem_rdata(a_mem_rdata), .resp_valid(a_resp_valid),
        .resp_ch(a_resp_ch), .resp_addr(a_resp_addr), .resp_data(a_resp_data));

    mem_arbiter #(.NCH(4), .QLOG(3), .AW(16), .DW(16), .RR(1)) u_b (
        .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_addr(b_req_addr),
        .q_full(b_q_full), .q_ovf(b_q_ovf), .mem_re(b_mem_re), .mem_raddr(b_mem_raddr),
        .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata), .resp_valid(b_resp_valid),
        .resp_ch(b_resp_ch), .resp_addr(b_resp_addr), .resp_data(b_resp_data));

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        int          ch;
        logic [15:0] addr;
        logic [15:0] data;
        int          lat;
        int          exp_ch;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;
    vec_t tbl[4];

    typedef struct {
        logic [15:0] addr;
        int          edge_n;
    } ent_t;
    typedef struct {
        int          ch;
        logic [15:0] addr;
    } rsp_t;

    ent_t        mq[4][$];
    rsp_t        rsp_q[$];
    logic [15:0] iss_q[$], rsp_exp[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic a_push(input int ch, input logic [15:0] addr);
        a_req_valid = '0;
        a_req_addr  = '0;
        a_req_valid[ch] = 1'b1;
        a_req_addr[ch*16 +: 16] = addr;
    endtask

    task automatic a_single(input vec_t v);
        a_push(v.ch, v.addr);
        step();
        a_req_valid = '0;
        step();
        chk("issue_early", a_mem_re, 0);
        step();
        chk("issue_re", a_mem_re, 1);
        chk("issue_addr", a_mem_raddr, v.exp_addr);
        for (int i = 0; i < v.lat; i++) begin
            step();
            chk("re_pulse", a_mem_re, 0);
            chk("resp_early", a_resp_valid, 0);
        end
        a_mem_ready = 1'b1;
        a_mem_rdata = v.data;
        step();
        a_mem_ready = 1'b0;
        a_mem_rdata = '0;
        chk("resp_valid", a_resp_valid, 1);
        chk("resp_ch", a_resp_ch, v.exp_ch);
        chk("resp_addr", a_resp_addr, v.exp_addr);
        chk("resp_data", a_resp_data, v.exp_data);
        step();
        chk("resp_pulse", a_resp_valid, 0);
        chk("resp_hold", a_resp_addr, v.exp_addr);
    endtask

    // Holds mem_ready high; checks issue order against iss_q and responses
    // against rsp_exp, with data = addr ^ 0x5555.
    task automatic a_drain(input int budget);
        logic [15:0] e;
        a_mem_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            a_mem_rdata = a_mem_raddr ^ 16'h5555;
            step();
            if (a_resp_valid) begin
                if (rsp_exp.size() == 0) fail("drain_extra_resp");
                else begin
                    e = rsp_exp.pop_front();
                    chk("drain_resp_addr", a_resp_addr, e);
                    chk("drain_resp_data", a_resp_data, e ^ 16'h5555);
                end
            end
            if (a_mem_re) begin
                if (iss_q.size() == 0) fail("drain_extra_issue");
                else chk("drain_issue", a_mem_raddr, iss_q.pop_front());
            end
        end
        a_mem_ready = 1'b0;
        a_mem_rdata = '0;
        chk("drain_left", iss_q.size() + rsp_exp.size(), 0);
    endtask

    int          k, rch, last_ch, lat, seq, wch;
    bit          outstanding, found;
    logic [15:0] ra;
    rsp_t        r;

    initial begin
        tbl[0] = '{0, 16'h0010, 16'hBEEF, 3, 0, 16'h0010, 16'hBEEF};
        tbl[1] = '{1, 16'hFFFF, 16'h0000, 0, 1, 16'hFFFF, 16'h0000};
        tbl[2] = '{0, 16'h0000, 16'hFFFF, 1, 0, 16'h0000, 16'hFFFF};
        tbl[3] = '{1, 16'h1234, 16'h5A5A, 5, 1, 16'h1234, 16'h5A5A};

        a_reset = 1'b1; a_req_valid = '0; a_req_addr = '0; a_mem_ready = 1'b0; a_mem_rdata = '0;
        b_reset = 1'b1; b_req_valid = '0; b_req_addr = '0; b_mem_ready = 1'b0; b_mem_rdata = '0;
        step();
        step();
        chk("rst_q_full", a_q_full, 0);
        chk("rst_q_ovf", a_q_ovf, 0);
        chk("rst_mem_re", a_mem_re, 0);
        chk("rst_mem_raddr", a_mem_raddr, 0);
        chk("rst_resp_valid", a_resp_valid, 0);
        chk("rst_resp_ch", a_resp_ch, 0);
        chk("rst_resp_addr", a_resp_addr, 0);
        chk("rst_resp_data", a_resp_data, 0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) a_single(tbl[i]);

        // same-cycle pushes: ch1 first, then ch0 granted on the mem_ready edge
        a_req_valid = 2'b11;
        a_req_addr  = {16'h0200, 16'h0100};
        step();
        a_req_valid = '0;
        step();
        step();
        chk("pri_first_re", a_mem_re, 1);
        chk("pri_first_addr", a_mem_raddr, 16'h0200);
        a_mem_ready = 1'b1;
        a_mem_rdata = 16'h2222;
        step();
        a_mem_ready = 1'b0;
        chk("pri_resp1_ch", a_resp_ch, 1);
        chk("pri_resp1_addr", a_resp_addr, 16'h0200);
        chk("b2b_grant_addr", a_mem_raddr, 16'h0100);
        chk("b2b_re_low", a_mem_re, 0);
        step();
        chk("b2b_re", a_mem_re, 1);
        a_mem_ready = 1'b1;
        a_mem_rdata = 16'h1111;
        step();
        a_mem_ready = 1'b0;
        chk("pri_resp2_ch", a_resp_ch, 0);
        chk("pri_resp2_data", a_resp_data, 16'h1111);
        step();

        // overflow: memory stalled on ch0, push 5 to ch1 (depth 4)
        a_push(0, 16'h0A00);
        step();
        a_req_valid = '0;
        step();
        step();
        chk("ovf_stall_re", a_mem_re, 1);
        for (int n = 0; n < 5; n++) begin
            a_push(1, 16'h0B00 + 16'(n));
            step();
            chk("ovf_full", a_q_full[1], (n >= 3) ? 1 : 0);
            chk("ovf_flag", a_q_ovf[1], (n == 4) ? 1 : 0);
        end
        a_req_valid = '0;
        rsp_exp = '{16'h0A00, 16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03};
        iss_q   = '{16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03};
        a_drain(40);
        chk("ovf_sticky", a_q_ovf[1], 1);

        // full queue with push and pop on the same edge
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        chk("rst_ovf_clear", a_q_ovf, 0);
        a_push(0, 16'h0C00);
        step();
        a_req_valid = '0;
        step();
        step();
        for (int n = 0; n < 4; n++) begin
            a_push(1, 16'h0D00 + 16'(n));
            step();
        end
        chk("pp_full_before", a_q_full[1], 1);
        a_push(1, 16'h0D04);
        a_mem_ready = 1'b1;
        a_mem_rdata = 16'h0C0C;
        step();
        a_req_valid = '0;
        a_mem_ready = 1'b0;
        chk("pp_full_after", a_q_full[1], 1);
        chk("pp_ovf", a_q_ovf[1], 0);
        chk("pp_resp_addr", a_resp_addr, 16'h0C00);
        rsp_exp = '{16'h0D00, 16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04};
        iss_q   = '{16'h0D00, 16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04};
        a_drain(40);

        // reset while waiting on memory; the late mem_ready must be ignored
        a_push(0, 16'h0E00);
        step();
        a_req_valid = '0;
        step();
        step();
        chk("rw_re", a_mem_re, 1);
        step();
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        a_mem_ready = 1'b1;
        a_mem_rdata = 16'hDEAD;
        step();
        a_mem_ready = 1'b0;
        chk("rw_q_full", a_q_full, 0);
        chk("rw_resp_addr", a_resp_addr, 0);
        for (int i = 0; i < 4; i++) begin
            chk("rw_no_resp", a_resp_valid, 0);
            chk("rw_no_re", a_mem_re, 0);
            step();
        end
        a_single('{1, 16'h0F0F, 16'hCAFE, 2, 1, 16'h0F0F, 16'hCAFE});

        // round-robin: 4 channels x 2 entries, addr = ch*0x10 + n
        b_req_valid = 4'hF;
        for (int c = 0; c < 4; c++) b_req_addr[c*16 +: 16] = 16'(c * 16);
        step();
        for (int c = 0; c < 4; c++) b_req_addr[c*16 +: 16] = 16'(c * 16 + 1);
        step();
        b_req_valid = '0;
        k = 0;
        for (int i = 0; i < 80 && k < 8; i++) begin
            b_mem_ready = 1'b1;
            b_mem_rdata = b_mem_raddr;
            step();
            if (b_mem_re) begin
                chk("rr_order", b_mem_raddr, 16'((k % 4) * 16 + k / 4));
                k++;
            end
        end
        chk("rr_count", k, 8);
        step();
        b_mem_ready = 1'b0;
        b_reset = 1'b1;
        step();
        b_reset = 1'b0;

        // random traffic against a transaction-level round-robin model
        last_ch = 3; seq = 0; outstanding = 0; lat = 0;
        for (int t = 0; t < 3400; t++) begin
            b_req_valid = '0;
            b_mem_ready = 1'b0;
            if (t < 3000 && $urandom_range(0, 9) == 0) begin
                rch = $urandom_range(0, 3);
                ra  = 16'((rch << 14) | (seq & 16'h3FFF));
                seq++;
                b_req_valid[rch] = 1'b1;
                b_req_addr[rch*16 +: 16] = ra;
                mq[rch].push_back('{ra, cyc + 1});
            end
            if (outstanding) begin
                if (lat == 0) begin
                    b_mem_ready = 1'b1;
                    b_mem_rdata = b_mem_raddr ^ 16'h3C3C;
                    outstanding = 0;
                end else lat--;
            end else if ($urandom_range(0, 15) == 0) begin
                b_mem_ready = 1'b1;
                b_mem_rdata = 16'hFFFF;
            end
            step();
            if (b_resp_valid) begin
                if (rsp_q.size() == 0) fail("rnd_extra_resp");
                else begin
                    r = rsp_q.pop_front();
                    chk("rnd_resp_ch", b_resp_ch, r.ch);
                    chk("rnd_resp_addr", b_resp_addr, r.addr);
                    chk("rnd_resp_data", b_resp_data, r.addr ^ 16'h3C3C);
                end
            end
            if (b_mem_re) begin
                // grant happened one edge ago; only entries pushed before it count
                found = 0;
                wch = 0;
                for (int j = 1; j <= 4; j++) begin
                    rch = (last_ch + j) % 4;
                    if (!found && mq[rch].size() > 0 && mq[rch][0].edge_n <= cyc - 2) begin
                        found = 1;
                        wch = rch;
                    end
                end
                if (!found) fail("rnd_spurious_grant");
                else begin
                    chk("rnd_issue_addr", b_mem_raddr, mq[wch][0].addr);
                    rsp_q.push_back('{wch, mq[wch][0].addr});
                    void'(mq[wch].pop_front());
                    last_ch = wch;
                end
                outstanding = 1;
                lat = $urandom_range(0, 3);
            end
        end
        chk("rnd_left", mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()
            + rsp_q.size() + int'(outstanding), 0);
        chk("rnd_no_ovf", b_q_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised successor to the two-queue memory controller.
- Accepts read requests on NCH independent channels and buffers each channel in its own FIFO of depth 2**QLOG.
- Arbitrates the channels onto one shared single-outstanding memory read port and broadcasts every completed read tagged with its channel.
- Adds selectable fixed or round-robin priority, overflow flags instead of simulation halt, and synchronous reset.

Parameters:
- NCH, 2, number of request channels (1..8).
- QLOG, 3, log2 of per-channel queue depth.
- AW, 16, address width.
- DW, 16, data width.
- RR, 0, arbitration mode: 0 = fixed priority (highest channel index wins), 1 = round-robin.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NCH  per-channel request strobe; one request per asserted bit per cycle.
- req_addr  in  NCH*AW  per-channel read address; channel c occupies bits [c*AW +: AW].
- q_full  out  NCH  per-channel queue full, combinational from occupancy.
- q_ovf  out  NCH  sticky per-channel overflow flag.
- mem_re  out  1  memory read enable, one-cycle pulse.
- mem_raddr  out  AW  memory read address, held from GRANT until next GRANT.
- mem_ready  in  1  memory response valid.
- mem_rdata  in  DW  memory response data.
- resp_valid  out  1  broadcast response strobe, one cycle.
- resp_ch  out  clog2(NCH) (min 1)  channel that owns the response.
- resp_addr  out  AW  address of the response.
- resp_data  out  DW  data of the response.

Behaviour:
- Reset values: all queues empty, q_full=0, q_ovf=0, mem_re=0, mem_raddr=0, resp_valid=0, resp_ch=0, resp_addr=0, resp_data=0, state=IDLE, rr_ptr=NCH-1.
- Queue push: a channel pushes when req_valid[c]=1 at a posedge; the entry is visible to the arbiter at the next edge.
- Full queue: a push is dropped and q_ovf[c] is set; q_ovf is cleared only by reset.
- Push and pop on the same queue in the same cycle are legal and leave occupancy unchanged.
  - This holds even when the queue is full, since the pop frees the slot first and q_ovf is not set.
- Read and write pointers are QLOG bits and wrap modulo 2**QLOG; full/empty come from a QLOG+1-bit count.
- State machine:
  - IDLE: if any queue is non-empty, select a winner, latch its head into mem_raddr and the winner index into cur_ch, pop it, go to ISSUE; else stay.
  - ISSUE: mem_re=1 for exactly this cycle, go to WAIT.
  - WAIT: mem_re=0. On mem_ready=1, capture resp_addr=mem_raddr, resp_data=mem_rdata, resp_ch=cur_ch, and set resp_valid=1 the following cycle. Then go directly to GRANT behaviour if any queue is non-empty (same edge, as in IDLE), else IDLE.
- Arbitration:
  - RR=0: highest-index non-empty channel wins.
  - RR=1: first non-empty channel searching cur+1, cur+2, … modulo NCH from rr_ptr; rr_ptr is updated to the winner on each grant.
- Latency with empty system: req_valid sampled at edge 0 → grant at edge 1 → mem_re high between edges 2 and 3. resp_valid is high exactly one cycle, starting the edge after mem_ready is sampled.
- Only one memory request is outstanding at a time. mem_ready outside WAIT is ignored and produces no resp_valid.
- Reset mid-operation: queued and in-flight requests are discarded, and a late mem_ready after reset is ignored.
- resp_* fields hold their last value while resp_valid=0.

Test Plan:
- NCH=2, RR=0: reset, push ch0 addr 0x0010 → mem_re pulse with mem_raddr=0x0010 in cycle 2; memory returns 0xBEEF after 3 cycles → resp_valid one cycle with resp_ch=0, resp_addr=0x0010, resp_data=0xBEEF.
- NCH=2, RR=0, same-cycle pushes ch0=0x0100 and ch1=0x0200 → issue order 0x0200 then 0x0100, back-to-back with no IDLE cycle between the mem_ready and the next grant.
- NCH=4, RR=1, all channels hold 2 entries (addr = ch*0x10 + n) → grant channel order 0,1,2,3,0,1,2,3.
- QLOG=2: push 5 entries to ch1 while memory stalls mem_ready → q_full[1]=1 after 4 pushes, q_ovf[1]=1 after the 5th. The 5th address is never issued; the other 4 complete in FIFO order.
- Full queue with simultaneous push and pop (at a grant) → occupancy stays 4 and q_ovf stays 0.
- Assert reset during WAIT, then raise mem_ready → no resp_valid, mem_re=0, q_full=0, queues empty, and new requests then work normally.
